// File: rtl/operand_queue.sv
// Operand queue: pairs a stream of VRF operands with per-instruction commands (cnt, id) and tags each operand with its id and a last flag.
// Latency: 1 cycle from operand push to opq_valid_o through the FIFO; 0 cycles when OPERAND_QUEUE_BYPASS_EN is defined and the FIFO is empty.
// Backpressure: op_ready_o / cmd_ready_o are the registered not-full flags of the two FIFOs; opq_ready_i never reaches them combinationally.

package operand_queue_pkg;
  typedef logic [7:0]  acc_cnt_t;
  typedef logic [3:0]  insn_id_t;
  typedef logic [31:0] vrf_data_t;
endpackage

// Generic FIFO with extra-bit pointers; exposes the head and the entry behind it.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: the caller must not push while full_o is high.
module operand_queue_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             multi_o,
  output logic [Width-1:0] head_o,
  output logic [Width-1:0] next_o
);
  localparam int AW = $clog2(Depth);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d, rd_next;
  logic [Width-1:0] mem_q [Depth];

  assign rd_next = rd_q + (AW+1)'(1);
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // Two or more entries: the slot after the head holds a valid word.
  assign multi_o = !empty_o && (rd_next != wr_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign next_o  = mem_q[rd_next[AW-1:0]];

  // Pointer advance; the extra MSB tells full from empty after wrap.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + (AW+1)'(1);
    if (pop_i)  rd_d = rd_next;
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// Operand queue top. Optional feature macro: OPERAND_QUEUE_BYPASS_EN (empty-FIFO combinational bypass).
// Latency: 1 cycle push-to-output by default, 0 cycles via bypass when enabled.
// Backpressure: opq_valid_o holds data/id/last stable until opq_ready_i; zero-count commands are accepted and dropped.
module operand_queue
  import operand_queue_pkg::*;
#(
  parameter int DataDepth = 4,
  parameter int CmdDepth  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [$bits(acc_cnt_t)-1:0]    cmd_cnt_i,
  input  logic [$bits(insn_id_t)-1:0]    cmd_id_i,
  input  logic                           op_valid_i,
  output logic                           op_ready_o,
  input  logic [$bits(vrf_data_t)-1:0]   operand_i,
  output logic                           opq_valid_o,
  input  logic                           opq_ready_i,
  output logic [$bits(vrf_data_t)-1:0]   opq_data_o,
  output logic                           opq_last_o,
  output logic [$bits(insn_id_t)-1:0]    opq_id_o,
  output logic                           idle_o
);
  localparam int CntW = $bits(acc_cnt_t);
  localparam int IdW  = $bits(insn_id_t);
  localparam int CmdW = CntW + IdW;

  logic            data_full, data_empty, data_push, data_pop;
  logic            cmd_full, cmd_empty, cmd_multi, cmd_push, retire;
  logic            bypass_sel, xfer;
  vrf_data_t       data_head;
  logic [CmdW-1:0] cmd_wdata, cmd_head, cmd_next;
  acc_cnt_t        rem_q, rem_d;
  logic            unused_data_multi;
  vrf_data_t       unused_data_next;

  assign cmd_wdata = {cmd_cnt_i, cmd_id_i};

`ifdef OPERAND_QUEUE_BYPASS_EN
  // With no buffered operand but a live command, the incoming operand goes straight out.
  assign bypass_sel = data_empty && !cmd_empty;
`else
  assign bypass_sel = 1'b0;
`endif

  assign op_ready_o  = !data_full;
  assign cmd_ready_o = !cmd_full;
  assign idle_o      = data_empty && cmd_empty;

  assign opq_valid_o = bypass_sel ? op_valid_i : (!data_empty && !cmd_empty);
  assign opq_data_o  = bypass_sel ? operand_i : data_head;
  assign opq_id_o    = cmd_head[IdW-1:0];
  assign opq_last_o  = opq_valid_o && (rem_q == acc_cnt_t'(1));

  assign xfer      = opq_valid_o && opq_ready_i;
  assign retire    = xfer && (rem_q == acc_cnt_t'(1));
  assign data_pop  = xfer && !bypass_sel;
  // A bypassed operand is consumed on the spot and never written.
  assign data_push = op_valid_i && op_ready_o && !(bypass_sel && opq_ready_i);
  // Zero-count commands complete the handshake but are never stored.
  assign cmd_push  = cmd_valid_i && cmd_ready_o && (cmd_cnt_i != '0);

  operand_queue_fifo #(
    .Width ($bits(vrf_data_t)),
    .Depth (DataDepth)
  ) u_data_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (data_push),
    .pop_i   (data_pop),
    .wdata_i (operand_i),
    .full_o  (data_full),
    .empty_o (data_empty),
    .multi_o (unused_data_multi),
    .head_o  (data_head),
    .next_o  (unused_data_next)
  );

  operand_queue_fifo #(
    .Width (CmdW),
    .Depth (CmdDepth)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_push),
    .pop_i   (retire),
    .wdata_i (cmd_wdata),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .multi_o (cmd_multi),
    .head_o  (cmd_head),
    .next_o  (cmd_next)
  );

  // Remaining-operand count of the head command: reload on new head, count down per pop.
  always_comb begin
    rem_d = rem_q;
    if (retire) begin
      if (cmd_multi)     rem_d = cmd_next[CmdW-1 -: CntW];
      else if (cmd_push) rem_d = cmd_cnt_i;
      else               rem_d = '0;
    end else if (xfer) begin
      rem_d = rem_q - acc_cnt_t'(1);
    end else if (cmd_empty && cmd_push) begin
      rem_d = cmd_cnt_i;
    end
  end

  // Remaining-count register, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rem_q <= '0;
    else         rem_q <= rem_d;
  end
endmodule

// File: tb/tb_operand_queue.sv
// Self-checking bench for operand_queue: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed output sequences.
// Honours OPERAND_QUEUE_BYPASS_EN to pick the zero- or one-cycle expectations.
module tb_operand_queue;
  import operand_queue_pkg::*;

  localparam int DataDepth = 4;
  localparam int CmdDepth  = 2;
`ifdef OPERAND_QUEUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic      clk, rst_n;
  logic      cmd_valid, cmd_ready, op_valid, op_ready;
  acc_cnt_t  cmd_cnt;
  insn_id_t  cmd_id;
  vrf_data_t operand, opq_data;
  logic      opq_valid, opq_ready, opq_last, idle;
  insn_id_t  opq_id;

  operand_queue #(.DataDepth(DataDepth), .CmdDepth(CmdDepth)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_cnt_i   (cmd_cnt),
    .cmd_id_i    (cmd_id),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .operand_i   (operand),
    .opq_valid_o (opq_valid),
    .opq_ready_i (opq_ready),
    .opq_data_o  (opq_data),
    .opq_last_o  (opq_last),
    .opq_id_o    (opq_id),
    .idle_o      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain queues ----------------
  typedef struct { int cnt; int id; } mcmd_t;
  mcmd_t     mcq[$];
  vrf_data_t mdq[$];
  int        consumed = 0;

  function automatic bit m_byp();
    return Byp && (mdq.size() == 0) && (mcq.size() > 0);
  endfunction
  function automatic bit m_valid();
    return m_byp() ? op_valid : ((mdq.size() > 0) && (mcq.size() > 0));
  endfunction
  function automatic vrf_data_t m_data();
    return m_byp() ? operand : mdq[0];
  endfunction
  function automatic bit m_last();
    return m_valid() && (mcq[0].cnt - consumed == 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcq.delete();
      mdq.delete();
      consumed = 0;
    end else begin
      bit byp, x, opacc, cmdacc;
      byp    = m_byp();
      x      = m_valid() && opq_ready;
      opacc  = op_valid && (mdq.size() < DataDepth);
      cmdacc = cmd_valid && (mcq.size() < CmdDepth) && (cmd_cnt != 0);
      if (x && !byp) void'(mdq.pop_front());
      if (opacc && !(byp && opq_ready)) mdq.push_back(operand);
      if (x) begin
        consumed++;
        if (consumed == mcq[0].cnt) begin
          void'(mcq.pop_front());
          consumed = 0;
        end
      end
      if (cmdacc) mcq.push_back('{int'(cmd_cnt), int'(cmd_id)});
    end
  end

  always @(posedge clk) cyc_n++;

  // ---------------- per-cycle compare and output log ----------------
  typedef struct { vrf_data_t d; int id; bit last; int cyc; } ev_t;
  ev_t log_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_opq_valid", opq_valid, 0);
      check("rst_opq_last", opq_last, 0);
      check("rst_idle", idle, 1);
      check("rst_op_ready", op_ready, 1);
      check("rst_cmd_ready", cmd_ready, 1);
    end else begin
      check("cmd_ready", cmd_ready, mcq.size() < CmdDepth);
      check("op_ready", op_ready, mdq.size() < DataDepth);
      check("idle", idle, (mdq.size() == 0) && (mcq.size() == 0));
      check("opq_valid", opq_valid, m_valid());
      check("opq_last", opq_last, m_last());
      if (m_valid()) begin
        check("opq_data", opq_data, m_data());
        check("opq_id", opq_id, mcq[0].id);
      end
      if (opq_valid && opq_ready)
        log_q.push_back('{opq_data, int'(opq_id), opq_last, cyc_n});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int cnt, input int id);
    cmd_valid = 1'b1;
    cmd_cnt   = acc_cnt_t'(cnt);
    cmd_id    = insn_id_t'(id);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_op(input vrf_data_t d);
    op_valid = 1'b1;
    operand  = d;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic expect_ev(input string name, input int idx, input vrf_data_t d, input int id, input bit last);
    if (idx < log_q.size()) begin
      check({name, "_data"}, log_q[idx].d, d);
      check({name, "_id"}, log_q[idx].id, id);
      check({name, "_last"}, log_q[idx].last, last);
    end
  endtask

  int base;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_cnt = '0; cmd_id = '0;
    op_valid = 1'b0; operand = '0; opq_ready = 1'b0;
    #2;
    check("reset_idle_lit", idle, 1);
    check("reset_op_ready_lit", op_ready, 1);
    check("reset_valid_lit", opq_valid, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // S1: cnt=3 id=5, A B C back to back
    opq_ready = 1'b1;
    base = log_q.size();
    send_cmd(3, 5);
    push_op(32'hA0A0_0001);
    push_op(32'hB0B0_0002);
    push_op(32'hC0C0_0003);
    repeat (3) tick();
    check("s1_count", log_q.size() - base, 3);
    expect_ev("s1_a", base + 0, 32'hA0A0_0001, 5, 1'b0);
    expect_ev("s1_b", base + 1, 32'hB0B0_0002, 5, 1'b0);
    expect_ev("s1_c", base + 2, 32'hC0C0_0003, 5, 1'b1);
    check("s1_idle", idle, 1);

    // S2: fill the operand FIFO with the consumer stalled
    opq_ready = 1'b0;
    base = log_q.size();
    send_cmd(4, 3);
    push_op(32'hD000_0000);
    push_op(32'hD000_0001);
    push_op(32'hD000_0002);
    push_op(32'hD000_0003);
    #2;
    check("s2_full_op_ready", op_ready, 0);
    check("s2_hold_data0", opq_data, 32'hD000_0000);
    tick(); #2;
    check("s2_hold_data1", opq_data, 32'hD000_0000);
    check("s2_hold_valid", opq_valid, 1);
    tick();
    opq_ready = 1'b1;
    tick();
    opq_ready = 1'b0;
    #2;
    check("s2_op_ready_back", op_ready, 1);
    opq_ready = 1'b1;
    repeat (5) tick();
    check("s2_count", log_q.size() - base, 4);
    expect_ev("s2_d0", base + 0, 32'hD000_0000, 3, 1'b0);
    expect_ev("s2_d3", base + 3, 32'hD000_0003, 3, 1'b1);

    // S3: two commands, operand stream crosses the boundary without a bubble
    base = log_q.size();
    send_cmd(1, 1);
    send_cmd(2, 2);
    push_op(32'h0000_00A1);
    push_op(32'h0000_00A2);
    push_op(32'h0000_00A3);
    repeat (4) tick();
    check("s3_count", log_q.size() - base, 3);
    expect_ev("s3_x", base + 0, 32'h0000_00A1, 1, 1'b1);
    expect_ev("s3_y", base + 1, 32'h0000_00A2, 2, 1'b0);
    expect_ev("s3_z", base + 2, 32'h0000_00A3, 2, 1'b1);
    if (log_q.size() - base == 3) begin
      check("s3_no_bubble_xy", log_q[base + 1].cyc - log_q[base].cyc, 1);
      check("s3_no_bubble_yz", log_q[base + 2].cyc - log_q[base + 1].cyc, 1);
    end

    // S4: operand ahead of its command
    push_op(32'h5555_AAAA);
    #2;
    check("s4_wait0", opq_valid, 0);
    tick();
    cmd_valid = 1'b1; cmd_cnt = 8'd1; cmd_id = 4'd6;
    #2;
    check("s4_wait_cmd_cycle", opq_valid, 0);
    tick();
    cmd_valid = 1'b0;
    #2;
    check("s4_valid", opq_valid, 1);
    check("s4_data", opq_data, 32'h5555_AAAA);
    check("s4_id", opq_id, 6);
    check("s4_last", opq_last, 1);
    repeat (2) tick();

    // S5: reset in the middle of a cnt=4 instruction
    opq_ready = 1'b0;
    send_cmd(4, 7);
    push_op(32'h7000_0000);
    push_op(32'h7000_0001);
    #2;
    check("s5_valid_before", opq_valid, 1);
    base = log_q.size();
    rst_n = 1'b0;
    #1;
    check("s5_idle_now", idle, 1);
    check("s5_valid_now", opq_valid, 0);
    check("s5_last_now", opq_last, 0);
    tick(); tick();
    rst_n = 1'b1;
    opq_ready = 1'b1;
    repeat (3) tick();
    check("s5_no_output", log_q.size() - base, 0);

    // S6: zero-count command dropped, then bypass / one-cycle latency
    send_cmd(0, 9);
    #2;
    check("s6_zero_cnt_idle", idle, 1);
    tick();
    base = log_q.size();
    send_cmd(2, 4);
    op_valid = 1'b1;
    operand  = 32'hBEEF_0000;
    #2;
    check("s6_same_cycle_valid", opq_valid, Byp ? 1 : 0);
    tick();
    operand = 32'hBEEF_0001;
    #2;
    check("s6_next_valid", opq_valid, 1);
    check("s6_next_data", opq_data, Byp ? 32'hBEEF_0001 : 32'hBEEF_0000);
    tick();
    op_valid = 1'b0;
    repeat (3) tick();
    check("s6_count", log_q.size() - base, 2);
    expect_ev("s6_v0", base + 0, 32'hBEEF_0000, 4, 1'b0);
    expect_ev("s6_v1", base + 1, 32'hBEEF_0001, 4, 1'b1);
    check("s6_idle_end", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
